mex_ctrl: RTL
=============

MEX_CTRL -- requirements
Module: mex_ctrl

Interface
REQ-001 Parameters: none; operand width fixed at 32.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  reset, asynchronous, active-low: state clears while rst=0, independent of clk.
REQ-004 start  in  1  request a new M-extension operation; accepted only in IDLE.
REQ-005 funct3  in  3  operation select, mex_funct3_t: mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
REQ-006 rs1_data  in  32  operand A (multiplicand/dividend).
REQ-007 rs2_data  in  32  operand B (multiplier/divisor).
REQ-008 flush  in  1  abort any in-flight operation.
REQ-009 busy  out  1  high in every state except IDLE; pipeline stall request.
REQ-010 done  out  1  one-cycle pulse; result valid in that cycle.
REQ-011 result  out  32  operation result; holds its value until the next done.

Function
REQ-012 States: IDLE, MUL, DIV, FIX, DONE.
REQ-013 IDLE: start=1 and flush=0 latch funct3 and both operands; next state depends on funct3 and operands (REQ-014 to REQ-017).
REQ-014 Divide-family with rs2_data=0 -> DONE in next cycle; quotient 0xFFFFFFFF, remainder = rs1_data.
REQ-015 div/rem with rs1_data=0x80000000 and rs2_data=0xFFFFFFFF -> DONE in next cycle; quotient 0x80000000, remainder 0.
REQ-016 Other multiply ops -> MUL; other divide ops -> DIV.
REQ-017 Signedness: mul/mulh/div/rem treat both operands as signed; mulhsu treats A signed and B unsigned; mulhu/divu/remu treat both unsigned. Signed operands are converted to magnitudes at latch.
REQ-018 MUL: unsigned shift-add, 1 bit per cycle, exactly 32 cycles, 64-bit product.
REQ-019 DIV: restoring division, 1 quotient bit per cycle, exactly 32 cycles, 32-bit quotient and remainder.
REQ-020 FIX: one cycle. Negate the product if the operand signs differ. Negate the quotient if signs differ (signed ops only). Remainder takes the sign of the dividend.
REQ-021 Result selection: mul gives product[31:0]; mulh/mulhsu/mulhu give product[63:32]; div/divu give quotient; rem/remu give remainder.
REQ-022 DONE: done=1 and result registered for one cycle, then IDLE unconditionally.
REQ-023 Latency: start accepted in cycle 0 -> done in cycle 34 (MUL/DIV cycles 1-32, FIX 33); fast paths -> done in cycle 1.
REQ-024 start while busy=1 is ignored; operands are not re-latched.
REQ-025 flush=1 in any state -> IDLE next cycle, done not asserted, result unchanged.
REQ-026 flush=1 and start=1 in the same cycle -> start not accepted.
REQ-027 Back-to-back: start is accepted on the first IDLE cycle after DONE.
REQ-028 Operand inputs are ignored after latch; they may change freely during busy.

Reset
REQ-029 rst=0 forces state to IDLE, busy=0, done=0, result=0, and all iteration counters and accumulators to 0, asynchronously.
REQ-030 rst asserted mid-operation discards the operation; no done follows deassertion.
REQ-031 After rst deasserts, first start is accepted on the first rising edge with start=1.

Structure
REQ-032 mex_funct3_t stays in the shared rv32i_types package.
REQ-033 Add constant MEX_ITERATIONS=32 to rv32i_types.
REQ-034 The FSM state enum is local to mex_ctrl.
REQ-035 One sub-module, mex_iter_datapath, holds the accumulator, shift registers and 6-bit iteration counter.
REQ-036 mex_ctrl holds the FSM and the sign/fast-path logic.

Verification
REQ-037 mul 0x00000007 x 0xFFFFFFFD -> result 0xFFFFFFEB, done exactly in cycle 34, busy high in cycles 1-34.
REQ-038 mulh 0x80000000 x 0x80000000 -> 0x40000000; mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; mulhsu 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
REQ-039 div 0xFFFFFFF9 / 0x00000002 -> 0xFFFFFFFD; rem same operands -> 0xFFFFFFFF; divu same operands -> 0x7FFFFFFC.
REQ-040 divu 5/0 -> 0xFFFFFFFF, done in cycle 1; rem 5/0 -> 0x00000005; div 0x80000000/0xFFFFFFFF -> 0x80000000, done in cycle 1.
REQ-041 flush in cycle 10 of a div -> busy=0 in cycle 11, no done pulse; start with flush in the same cycle -> not accepted.
REQ-042 rst=0 mid-mul (cycle 15) -> busy, done and result are 0 before the next clock edge; no done after release.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32 type definitions used by the M-extension controller.
package rv32i_types;
  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } mex_funct3_t;
  localparam int unsigned MEX_ITERATIONS = 32;
endpackage

// File: rtl/mex_iter_datapath.sv
// mex_iter_datapath: shared shift-add multiplier / restoring divider, one bit per step.
module mex_iter_datapath
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        div_i,
  input  logic [31:0] sr_init_i,
  input  logic [31:0] opnd_init_i,
  output logic [63:0] prod_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o,
  output logic        last_o
);
  logic [31:0] acc_q, acc_d, sr_q, sr_d, opnd_q, div_trial;
  logic [32:0] mul_sum;
  logic [5:0]  cnt_q;
  logic        div_ok;
  // acc is the product high half / partial remainder; sr is the multiplier / dividend-quotient
  always_comb begin
    mul_sum   = {1'b0, acc_q} + {1'b0, sr_q[0] ? opnd_q : 32'd0};
    div_ok    = {acc_q, sr_q[31]} >= {1'b0, opnd_q};
    div_trial = {acc_q[30:0], sr_q[31]} - opnd_q;
    acc_d     = div_i ? (div_ok ? div_trial : {acc_q[30:0], sr_q[31]}) : mul_sum[32:1];
    sr_d      = div_i ? {sr_q[30:0], div_ok} : {mul_sum[0], sr_q[31:1]};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      sr_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      acc_q  <= '0;
      sr_q   <= sr_init_i;
      opnd_q <= opnd_init_i;
      cnt_q  <= '0;
    end else if (step_i) begin
      acc_q <= acc_d;
      sr_q  <= sr_d;
      cnt_q <= cnt_q + 6'd1;
    end
  end
  assign prod_o = {acc_q, sr_q};
  assign quot_o = sr_q;
  assign rem_o  = acc_q;
  assign last_o = cnt_q == 6'(MEX_ITERATIONS - 1);
endmodule

// File: rtl/mex_ctrl.sv
// mex_ctrl: RV32 M-extension sequencer; sign handling, fast paths and the control FSM.
module mex_ctrl
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  mex_funct3_t funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
  state_t      state_q;
  mex_funct3_t op_q;
  logic        neg_q_q, neg_r_q, last;
  logic        a_neg, b_neg, div_zero, div_ovf, fast, load, step;
  logic [31:0] result_q, a_mag, b_mag, fast_res, fix_res, quot, rem, quot_fix, rem_fix;
  logic [63:0] prod, prod_fix;
  always_comb begin
    a_neg    = rs1_data[31] && funct3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    b_neg    = rs2_data[31] && funct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    a_mag    = a_neg ? -rs1_data : rs1_data;
    b_mag    = b_neg ? -rs2_data : rs2_data;
    div_zero = funct3[2] && rs2_data == '0;
    div_ovf  = funct3 inside {F3_DIV, F3_REM} && rs1_data == 32'h8000_0000 && rs2_data == '1;
    fast     = div_zero || div_ovf;
    fast_res = div_zero ? (funct3[1] ? rs1_data : '1) : (funct3[1] ? '0 : 32'h8000_0000);
    load     = state_q == S_IDLE && start && !flush && !fast;
    step     = (state_q == S_MUL || state_q == S_DIV) && !flush;
    prod_fix = neg_q_q ? -prod : prod;
    quot_fix = neg_q_q ? -quot : quot;
    rem_fix  = neg_r_q ? -rem : rem;
    fix_res  = op_q == F3_MUL ? prod_fix[31:0] : !op_q[2] ? prod_fix[63:32] :
               op_q[1] ? rem_fix : quot_fix;
  end
  mex_iter_datapath u_dp (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .step_i      (step),
    .div_i       (op_q[2]),
    .sr_init_i   (funct3[2] ? a_mag : b_mag),
    .opnd_init_i (funct3[2] ? b_mag : a_mag),
    .prod_o      (prod),
    .quot_o      (quot),
    .rem_o       (rem),
    .last_o      (last)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= F3_MUL;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          op_q    <= funct3;
          neg_q_q <= a_neg ^ b_neg;
          neg_r_q <= a_neg;
          if (fast) result_q <= fast_res;
          state_q <= fast ? S_DONE : funct3[2] ? S_DIV : S_MUL;
        end
        S_MUL, S_DIV: if (last) state_q <= S_FIX;
        S_FIX: begin
          result_q <= fix_res;
          state_q  <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign busy   = state_q != S_IDLE;
  assign done   = state_q == S_DONE;
  assign result = result_q;
endmodule
